rc4_keystream_decryptor: RTL and testbench
==========================================

// Module: rc4_keystream_decryptor
// PURPOSE
//  RC4 PRGA stage, downstream of the key-schedule shuffler. Once the shuffled S array sits in the
//  shared S RAM, it generates one keystream byte per message byte and XORs it with the encrypted
//  ROM byte. Each result is written to the decrypted-message RAM.
//  It can also grade the plaintext as lowercase ASCII, so the key-search controller can reject a
//  wrong key early.
// PARAMETERS
//  RAM_WIDTH      8   data width of S RAM, encrypted ROM and decrypted RAM
//  RAM_LENGTH     8   S RAM address width; i, j and sum indices are RAM_LENGTH bits
//  MSG_LENGTH     32  number of message bytes to decrypt (1..2**MSG_ADDR_WIDTH)
//  MSG_ADDR_WIDTH 5   address width of the encrypted ROM and the decrypted RAM
//  CHECK_ASCII    1   1: abort on the first byte outside {0x61..0x7A, 0x20}; 0: never abort
// PORTS
//  clk            in   1               system clock, rising edge
//  reset          in   1               asynchronous, active-high; clears all state and outputs
//  start          in   1               level; its rising edge (via edge_detector) launches a run
//  finished       out  1               one-cycle pulse when the run ends (complete or aborted)
//  key_valid      out  1               result of the run; held until the next start edge
//  s_ram_out      in   RAM_WIDTH       S RAM read data
//  s_write_enable out  1               S RAM write strobe
//  s_ram_in       out  RAM_WIDTH       S RAM write data
//  s_address      out  RAM_LENGTH      S RAM address
//  enc_out        in   RAM_WIDTH       encrypted ROM read data
//  enc_address    out  MSG_ADDR_WIDTH  encrypted ROM address
//  dec_write_enable out 1              decrypted RAM write strobe
//  dec_ram_in     out  RAM_WIDTH       decrypted RAM write data
//  dec_address    out  MSG_ADDR_WIDTH  decrypted RAM address
// BEHAVIOUR
//  - Reset (async, any time, including mid-run): state=IDLE; i, j, k, si, sj, f and all outputs = 0.
//    No write strobe may be high after reset asserts. A run interrupted by reset is not resumed.
//  - All outputs are registered. Memories have synchronous read with 1-cycle latency, so a WT_*
//    state always separates an address update from the capture of its data.
//  - Algorithm: i=j=0 at start. For each k in 0..MSG_LENGTH-1:
//      i=i+1; j=j+s[i]; swap s[i],s[j]; f=s[s[i]+s[j]]; dec[k]=f^enc[k].
//    All index sums wrap modulo 2**RAM_LENGTH.
//  - FSM (9 cycles per byte):
//      IDLE -start_sig-> RD_SI -> WT_SI -> LD_SI -> WT_SJ -> LD_SJ -> WR_SJ -> RD_F -> WT_F -> LD_F
//      LD_F goes to RD_SI (next byte), or to DONE (last byte, or abort).
//      DONE -> IDLE.
//  - Per-state actions:
//      RD_SI: s_address=i+1; i is updated.
//      LD_SI: capture si; j=j+si; s_address=j.
//      LD_SJ: capture sj; write s[i]=sj.
//      WR_SJ: write s[j]=si.
//      RD_F:  s_address=si+sj; enc_address=k.
//      LD_F:  f=s_ram_out; dec_write_enable=1 for one cycle, dec_address=k, dec_ram_in=f^enc_out.
//  - Exactly 2 S writes and 1 dec write per byte, each strobe high for exactly 1 cycle.
//    The F read is issued only after both swap writes have committed.
//    If i==j, both writes carry the same value; this is legal.
//  - Abort (CHECK_ASCII=1): the offending byte is still written. The FSM then goes to DONE with
//    key_valid=0, and no further bytes are processed.
//  - Normal end: key_valid=1 if no abort occurred.
//  - finished is high for one cycle in DONE: 9*N+1 cycles after leaving IDLE, where N is the number
//    of bytes processed.
//  - key_valid is cleared on a start edge.
//  - A start edge outside IDLE is ignored. A start edge in DONE is also ignored.
// STRUCTURE
//  - rc4_pkg holds the state_t enum and the constants ASCII_LOWER_MIN=8'h61, ASCII_LOWER_MAX=8'h7A
//    and ASCII_SPACE=8'h20.
//  - Sub-module: the existing edge_detector on start. The plaintext-range check is an inline function.
//  - Top-level muxing gives the S RAM port to shuffler or decryptor; that muxing is outside this block.
// TESTING
//  1. Identity S (s[n]=n), MSG_LENGTH=1, enc[0]=0x63 -> i=1, j=1, f=s[2]=0x02; dec[0]=0x61;
//     key_valid=1; finished 10 cycles after leaving IDLE.
//  2. Same S, enc[0]=0x02 -> dec[0]=0x00; abort; key_valid=0; exactly 1 dec write; S swap of
//     s[1] with itself leaves s[1]=1.
//  3. Identity S, MSG_LENGTH=32, enc = golden model XOR "the quick brown fox..." -> all 32 dec bytes
//     match; S RAM contents match the software model.
//  4. Force j wrap: s[1]=0xFF -> j=0xFF; next byte j=(0xFF+s[2])&0xFF; f index (si+sj) wraps;
//     compare with the model.
//  5. Assert reset during WR_SJ of byte 3 -> outputs 0 in the same cycle. A new start then reruns
//     from i=j=0 on the restored S RAM and matches scenario 3.
//  6. Pulse start every cycle mid-run; CHECK_ASCII=0 with enc giving 0xFF bytes -> no restart, no
//     abort, finished once, key_valid=1.

Source files
------------

// File: rtl/rc4_pkg.sv
// rc4_pkg
//   Shared types and constants for the RC4 keystream decryptor.
//   - state_t         : decryptor FSM encoding (exposed as the internal `state` signal)
//   - ASCII_LOWER_MIN : lowest accepted plaintext byte ('a')
//   - ASCII_LOWER_MAX : highest accepted plaintext byte ('z')
//   - ASCII_SPACE     : the only accepted non-letter plaintext byte (' ')
package rc4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WT_SI,
        LD_SI,
        WT_SJ,
        LD_SJ,
        WR_SJ,
        RD_F,
        WT_F,
        LD_F,
        DONE
    } state_t;

    localparam logic [7:0] ASCII_LOWER_MIN = 8'h61;
    localparam logic [7:0] ASCII_LOWER_MAX = 8'h7A;
    localparam logic [7:0] ASCII_SPACE     = 8'h20;

endpackage

// File: rtl/edge_detector.sv
// edge_detector
//   Turns a level input into a one-cycle pulse on its rising edge.
//   Ports:
//     clk       in  system clock, rising edge
//     reset     in  asynchronous, active-high
//     signal_in in  level to watch
//     rise      out high in the cycle where signal_in is 1 and was 0 on the previous clock
module edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic signal_in,
    output logic rise
);

    logic signal_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            signal_d <= 1'b0;
        end else begin
            signal_d <= signal_in;
        end
    end

    assign rise = signal_in & ~signal_d;

endmodule

// File: rtl/rc4_keystream_decryptor.sv
// rc4_keystream_decryptor
//   RC4 PRGA stage. With the shuffled S array already in the S RAM, produces one keystream
//   byte per message byte, XORs it with the encrypted ROM byte and writes the result to the
//   decrypted-message RAM. Optionally aborts on the first plaintext byte that is not a
//   lowercase letter or a space, so a wrong key can be rejected early.
//
//   Control protocol: a rising edge on the `start` level launches a run, but only while the
//   FSM is in IDLE (edges in any other state, DONE included, are dropped). When the run ends,
//   `finished` pulses for exactly one cycle and `key_valid` carries the verdict until the
//   next accepted start edge clears it.
//
//   Ports:
//     clk, reset        clock (rising edge), asynchronous active-high reset
//     start             run request (level, edge-detected)
//     finished          one-cycle end-of-run pulse
//     key_valid         1 when the run completed without an ASCII abort
//     s_ram_out         S RAM read data (1-cycle synchronous read)
//     s_write_enable    S RAM write strobe
//     s_ram_in          S RAM write data
//     s_address         S RAM address
//     enc_out           encrypted ROM read data (1-cycle synchronous read)
//     enc_address       encrypted ROM address
//     dec_write_enable  decrypted RAM write strobe
//     dec_ram_in        decrypted RAM write data
//     dec_address       decrypted RAM address
module rc4_keystream_decryptor
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH      = 8,
    parameter int RAM_LENGTH     = 8,
    parameter int MSG_LENGTH     = 32,
    parameter int MSG_ADDR_WIDTH = 5,
    parameter int CHECK_ASCII    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      finished,
    output logic                      key_valid,
    input  logic [RAM_WIDTH-1:0]      s_ram_out,
    output logic                      s_write_enable,
    output logic [RAM_WIDTH-1:0]      s_ram_in,
    output logic [RAM_LENGTH-1:0]     s_address,
    input  logic [RAM_WIDTH-1:0]      enc_out,
    output logic [MSG_ADDR_WIDTH-1:0] enc_address,
    output logic                      dec_write_enable,
    output logic [RAM_WIDTH-1:0]      dec_ram_in,
    output logic [MSG_ADDR_WIDTH-1:0] dec_address
);

    localparam logic [MSG_ADDR_WIDTH-1:0] K_LAST  = MSG_ADDR_WIDTH'(MSG_LENGTH - 1);
    localparam logic [RAM_LENGTH-1:0]     IDX_ONE = RAM_LENGTH'(1);
    localparam logic [MSG_ADDR_WIDTH-1:0] K_ONE   = MSG_ADDR_WIDTH'(1);

    state_t                    state;
    logic [RAM_LENGTH-1:0]     i;
    logic [RAM_LENGTH-1:0]     j;
    logic [MSG_ADDR_WIDTH-1:0] k;
    logic [RAM_WIDTH-1:0]      si;
    logic [RAM_WIDTH-1:0]      sj;
    logic [RAM_WIDTH-1:0]      f;
    logic                      start_sig;
    logic [RAM_WIDTH-1:0]      plain;

    edge_detector u_start_edge (
        .clk       (clk),
        .reset     (reset),
        .signal_in (start),
        .rise      (start_sig)
    );

    // Plaintext of the byte being finished in LD_F: keystream byte from S RAM XOR ROM byte.
    assign plain = s_ram_out ^ enc_out;

    function automatic logic is_plain_text(input logic [RAM_WIDTH-1:0] b);
        return ((b >= RAM_WIDTH'(ASCII_LOWER_MIN)) && (b <= RAM_WIDTH'(ASCII_LOWER_MAX)))
               || (b == RAM_WIDTH'(ASCII_SPACE));
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            i                <= '0;
            j                <= '0;
            k                <= '0;
            si               <= '0;
            sj               <= '0;
            f                <= '0;
            finished         <= 1'b0;
            key_valid        <= 1'b0;
            s_write_enable   <= 1'b0;
            s_ram_in         <= '0;
            s_address        <= '0;
            enc_address      <= '0;
            dec_write_enable <= 1'b0;
            dec_ram_in       <= '0;
            dec_address      <= '0;
        end else begin
            // Strobes and the end pulse are one cycle wide unless re-asserted below.
            s_write_enable   <= 1'b0;
            dec_write_enable <= 1'b0;
            finished         <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_sig) begin
                        i         <= '0;
                        j         <= '0;
                        k         <= '0;
                        key_valid <= 1'b0;
                        state     <= RD_SI;
                    end
                end

                RD_SI: begin
                    i         <= i + IDX_ONE;
                    s_address <= i + IDX_ONE;
                    state     <= WT_SI;
                end

                WT_SI: state <= LD_SI;

                LD_SI: begin
                    si        <= s_ram_out;
                    j         <= j + RAM_LENGTH'(s_ram_out);
                    s_address <= j + RAM_LENGTH'(s_ram_out);
                    state     <= WT_SJ;
                end

                WT_SJ: state <= LD_SJ;

                // First half of the swap: s[i] <= s[j].
                LD_SJ: begin
                    sj             <= s_ram_out;
                    s_address      <= i;
                    s_ram_in       <= s_ram_out;
                    s_write_enable <= 1'b1;
                    state          <= WR_SJ;
                end

                // Second half of the swap: s[j] <= old s[i]. This write commits at the end
                // of RD_F, before the F address reaches the RAM in WT_F.
                WR_SJ: begin
                    s_address      <= j;
                    s_ram_in       <= si;
                    s_write_enable <= 1'b1;
                    state          <= RD_F;
                end

                RD_F: begin
                    s_address   <= RAM_LENGTH'(si) + RAM_LENGTH'(sj);
                    enc_address <= k;
                    state       <= WT_F;
                end

                WT_F: state <= LD_F;

                // The offending byte is still written before an abort.
                LD_F: begin
                    f                <= s_ram_out;
                    dec_write_enable <= 1'b1;
                    dec_address      <= k;
                    dec_ram_in       <= plain;
                    if ((CHECK_ASCII != 0) && !is_plain_text(plain)) begin
                        key_valid <= 1'b0;
                        finished  <= 1'b1;
                        state     <= DONE;
                    end else if (k == K_LAST) begin
                        key_valid <= 1'b1;
                        finished  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k     <= k + K_ONE;
                        state <= RD_SI;
                    end
                end

                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_keystream_decryptor.sv
// tb_rc4_keystream_decryptor
//   Two decryptor instances share clock and reset:
//     u0 : MSG_LENGTH=32, CHECK_ASCII=1
//     u1 : MSG_LENGTH=1,  CHECK_ASCII=0
//   Each has its own S RAM, encrypted ROM and decrypted RAM models with 1-cycle read latency.
//   Expected results come from a plain array implementation of the RC4 PRGA.
module tb_rc4_keystream_decryptor;

    localparam int BUDGET = 400;

    logic       clk = 1'b0;
    logic       reset;
    logic       start      [2];
    logic       finished   [2];
    logic       key_valid  [2];
    logic       s_we       [2];
    logic       dec_we     [2];
    logic [7:0] s_ram_out  [2];
    logic [7:0] s_din      [2];
    logic [7:0] s_addr     [2];
    logic [7:0] enc_out    [2];
    logic [7:0] dec_din    [2];
    logic [4:0] enc_addr   [2];
    logic [4:0] dec_addr   [2];

    logic [7:0] s_mem   [2][256];
    logic [7:0] enc_mem [2][32];
    logic [7:0] dec_mem [2][32];
    int dec_cnt [2] = '{0, 0};
    int s_cnt   [2] = '{0, 0};
    int fin_cnt [2] = '{0, 0};

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int init_s [256];
    int enc_v  [32];
    int pt     [32];
    int m_s    [256];
    int m_dec  [32];
    int m_n;
    bit m_kv;

    rc4_keystream_decryptor #(
        .RAM_WIDTH(8), .RAM_LENGTH(8), .MSG_LENGTH(32), .MSG_ADDR_WIDTH(5), .CHECK_ASCII(1)
    ) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .finished(finished[0]),
        .key_valid(key_valid[0]), .s_ram_out(s_ram_out[0]), .s_write_enable(s_we[0]),
        .s_ram_in(s_din[0]), .s_address(s_addr[0]), .enc_out(enc_out[0]),
        .enc_address(enc_addr[0]), .dec_write_enable(dec_we[0]), .dec_ram_in(dec_din[0]),
        .dec_address(dec_addr[0])
    );

    rc4_keystream_decryptor #(
        .RAM_WIDTH(8), .RAM_LENGTH(8), .MSG_LENGTH(1), .MSG_ADDR_WIDTH(5), .CHECK_ASCII(0)
    ) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .finished(finished[1]),
        .key_valid(key_valid[1]), .s_ram_out(s_ram_out[1]), .s_write_enable(s_we[1]),
        .s_ram_in(s_din[1]), .s_address(s_addr[1]), .enc_out(enc_out[1]),
        .enc_address(enc_addr[1]), .dec_write_enable(dec_we[1]), .dec_ram_in(dec_din[1]),
        .dec_address(dec_addr[1])
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory models and event counters ----------------
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (s_we[g]) begin
                s_mem[g][s_addr[g]] <= s_din[g];
                s_cnt[g] <= s_cnt[g] + 1;
            end
            s_ram_out[g] <= s_mem[g][s_addr[g]];
            enc_out[g]   <= enc_mem[g][enc_addr[g]];
            if (dec_we[g]) begin
                dec_mem[g][dec_addr[g]] <= dec_din[g];
                dec_cnt[g] <= dec_cnt[g] + 1;
            end
            if (finished[g]) fin_cnt[g] <= fin_cnt[g] + 1;
        end
    end

    // ---------------- reference model ----------------
    function automatic bit is_text(input int b);
        return ((b >= 97) && (b <= 122)) || (b == 32);
    endfunction

    task automatic model(input int len, input bit chk);
        int s [256];
        int i, j, t, f;
        i = 0; j = 0; m_n = 0; m_kv = 1'b1;
        for (int n = 0; n < 256; n++) s[n] = init_s[n];
        for (int kk = 0; kk < len; kk++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            f = s[(s[i] + s[j]) % 256];
            m_dec[kk] = f ^ enc_v[kk];
            m_n = kk + 1;
            if (chk && !is_text(m_dec[kk])) begin
                m_kv = 1'b0;
                break;
            end
        end
        for (int n = 0; n < 256; n++) m_s[n] = s[n];
    endtask

    // enc = keystream XOR pt, keystream taken from the model with a zero ROM
    task automatic make_enc(input int len);
        for (int kk = 0; kk < 32; kk++) enc_v[kk] = 0;
        model(len, 1'b0);
        for (int kk = 0; kk < len; kk++) enc_v[kk] = m_dec[kk] ^ pt[kk];
    endtask

    task automatic identity_s();
        for (int n = 0; n < 256; n++) init_s[n] = n;
    endtask

    task automatic random_s();
        int r, t;
        identity_s();
        for (int n = 255; n > 0; n--) begin
            r = $urandom_range(n, 0);
            t = init_s[n]; init_s[n] = init_s[r]; init_s[r] = t;
        end
    endtask

    task automatic random_pt();
        for (int kk = 0; kk < 32; kk++)
            pt[kk] = ($urandom_range(7, 0) == 0) ? 32 : 97 + $urandom_range(25, 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_mem(input int u);
        for (int n = 0; n < 256; n++) s_mem[u][n] <= 8'(init_s[n]);
        for (int kk = 0; kk < 32; kk++) begin
            enc_mem[u][kk] <= 8'(enc_v[kk]);
            dec_mem[u][kk] <= 8'h00;
        end
        @(negedge clk);
    endtask

    task automatic run_check(input int u, input int len, input bit chk, input string name);
        int cycles, d0, s0, f0, bad_dec, bad_s, first;
        bit done;
        logic kv_e0;
        load_mem(u);
        model(len, chk);
        d0 = dec_cnt[u]; s0 = s_cnt[u]; f0 = fin_cnt[u];
        start[u] = 1'b1;
        cycles = 0; done = 1'b0; kv_e0 = 1'bx;
        while (!done && cycles < BUDGET) begin
            @(posedge clk);
            cycles++;
            #1;
            if (cycles == 1) kv_e0 = key_valid[u];
            if (finished[u]) done = 1'b1;
        end
        @(negedge clk);
        start[u] = 1'b0;
        repeat (3) @(negedge clk);

        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: got no finished within %0d cycles, expected %0d", name, BUDGET, 9*m_n+1);
        end else if (cycles != 9*m_n + 1) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, cycles, 9*m_n+1);
        end
        checks++;
        if (kv_e0 !== 1'b0) begin
            failures++;
            $display("FAIL %s key_valid_clear: got %b after start edge, expected 0", name, kv_e0);
        end
        checks++;
        if (key_valid[u] !== m_kv) begin
            failures++;
            $display("FAIL %s key_valid: got %b, expected %b", name, key_valid[u], m_kv);
        end
        checks++;
        if (dec_cnt[u] - d0 != m_n) begin
            failures++;
            $display("FAIL %s dec_writes: got %0d, expected %0d", name, dec_cnt[u]-d0, m_n);
        end
        checks++;
        if (s_cnt[u] - s0 != 2*m_n) begin
            failures++;
            $display("FAIL %s s_writes: got %0d, expected %0d", name, s_cnt[u]-s0, 2*m_n);
        end
        checks++;
        if (fin_cnt[u] - f0 != 1) begin
            failures++;
            $display("FAIL %s finished_pulses: got %0d, expected 1", name, fin_cnt[u]-f0);
        end
        bad_dec = 0; first = -1;
        for (int kk = 0; kk < m_n; kk++)
            if (dec_mem[u][kk] !== 8'(m_dec[kk])) begin
                bad_dec++;
                if (first < 0) first = kk;
            end
        checks++;
        if (bad_dec != 0) begin
            failures++;
            $display("FAIL %s dec_data: %0d bad bytes, first dec[%0d] got %02h expected %02h",
                     name, bad_dec, first, dec_mem[u][first], 8'(m_dec[first]));
        end
        bad_s = 0; first = -1;
        for (int n = 0; n < 256; n++)
            if (s_mem[u][n] !== 8'(m_s[n])) begin
                bad_s++;
                if (first < 0) first = n;
            end
        checks++;
        if (bad_s != 0) begin
            failures++;
            $display("FAIL %s s_ram: %0d bad entries, first s[%0d] got %02h expected %02h",
                     name, bad_s, first, s_mem[u][first], 8'(m_s[first]));
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({finished[u], key_valid[u], s_we[u], s_din[u], s_addr[u], enc_addr[u],
                 dec_we[u], dec_din[u], dec_addr[u]} !== 38'd0) begin
                failures++;
                $display("FAIL reset_outputs u%0d: got %b, expected all zero", u,
                         {finished[u], key_valid[u], s_we[u], s_din[u], s_addr[u], enc_addr[u],
                          dec_we[u], dec_din[u], dec_addr[u]});
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        identity_s();
        for (int kk = 0; kk < 32; kk++) enc_v[kk] = 0;
        enc_v[0] = 8'h63;
        run_check(1, 1, 1'b0, "single_byte");
        checks++;
        if (dec_mem[1][0] !== 8'h61) begin
            failures++;
            $display("FAIL single_byte_value: got %02h, expected 61", dec_mem[1][0]);
        end
    endtask

    task automatic test_abort_first();
        identity_s();
        for (int kk = 0; kk < 32; kk++) enc_v[kk] = $urandom_range(255, 0);
        enc_v[0] = 8'h02;
        run_check(0, 32, 1'b1, "abort_first");
        checks++;
        if ({key_valid[0], dec_mem[0][0], s_mem[0][1]} !== {1'b0, 8'h00, 8'h01}) begin
            failures++;
            $display("FAIL abort_first_values: got kv=%b dec0=%02h s1=%02h, expected kv=0 dec0=00 s1=01",
                     key_valid[0], dec_mem[0][0], s_mem[0][1]);
        end
    endtask

    task automatic test_golden_msg(input string name);
        string msg;
        msg = "the quick brown fox jumps over t";
        identity_s();
        for (int kk = 0; kk < 32; kk++) pt[kk] = int'(msg[kk]);
        make_enc(32);
        run_check(0, 32, 1'b1, name);
    endtask

    task automatic test_j_wrap();
        identity_s();
        init_s[1] = 255;
        init_s[255] = 1;
        random_pt();
        make_enc(32);
        run_check(0, 32, 1'b1, "j_wrap");
    endtask

    task automatic test_random();
        int p;
        for (int it = 0; it < 4; it++) begin
            random_s();
            random_pt();
            make_enc(32);
            if (it % 2 == 1) begin
                p = $urandom_range(31, 1);
                // uppercase letter: outside the accepted set, forces an abort at byte p
                enc_v[p] = enc_v[p] ^ pt[p] ^ (65 + $urandom_range(25, 0));
            end
            run_check(0, 32, 1'b1, $sformatf("random_%0d", it));
        end
    endtask

    task automatic test_reset_mid_run();
        string msg;
        int cycles;
        msg = "the quick brown fox jumps over t";
        identity_s();
        for (int kk = 0; kk < 32; kk++) pt[kk] = int'(msg[kk]);
        make_enc(32);
        load_mem(0);
        start[0] = 1'b1;
        cycles = 0;
        // WR_SJ of byte index 2 is entered 9*2+5 edges after leaving IDLE
        while (cycles < 24) begin
            @(posedge clk);
            cycles++;
        end
        #1;
        checks++;
        if (s_we[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_run_strobe: got s_write_enable=%b in WR_SJ, expected 1", s_we[0]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({finished[0], key_valid[0], s_we[0], s_din[0], s_addr[0], enc_addr[0],
             dec_we[0], dec_din[0], dec_addr[0]} !== 38'd0) begin
            failures++;
            $display("FAIL mid_run_reset: got %b, expected all zero",
                     {finished[0], key_valid[0], s_we[0], s_din[0], s_addr[0], enc_addr[0],
                      dec_we[0], dec_din[0], dec_addr[0]});
        end
        start[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_golden_msg("rerun_after_reset");
    endtask

    task automatic test_start_spam();
        int cycles, d0, f0;
        bit done;
        identity_s();
        pt[0] = 8'hFF;
        make_enc(1);
        load_mem(1);
        model(1, 1'b0);
        d0 = dec_cnt[1]; f0 = fin_cnt[1];
        start[1] = 1'b1;
        cycles = 0; done = 1'b0;
        while (!done && cycles < 50) begin
            @(posedge clk);
            cycles++;
            #1;
            if (finished[1]) done = 1'b1;
            else begin
                @(negedge clk);
                start[1] = ~start[1];
            end
        end
        @(negedge clk);
        start[1] = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (!done || cycles != 10) begin
            failures++;
            $display("FAIL spam_latency: got done=%b cycles=%0d, expected done=1 cycles=10", done, cycles);
        end
        checks++;
        if (key_valid[1] !== 1'b1 || dec_mem[1][0] !== 8'hFF || dec_mem[1][0] !== 8'(m_dec[0])) begin
            failures++;
            $display("FAIL spam_result: got kv=%b dec0=%02h, expected kv=1 dec0=ff", key_valid[1], dec_mem[1][0]);
        end
        checks++;
        if (fin_cnt[1] - f0 != 1 || dec_cnt[1] - d0 != 1) begin
            failures++;
            $display("FAIL spam_restart: got finished=%0d dec_writes=%0d, expected 1 and 1",
                     fin_cnt[1]-f0, dec_cnt[1]-d0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        test_reset();
        test_single_byte();
        test_abort_first();
        test_golden_msg("golden_msg");
        test_j_wrap();
        test_random();
        test_reset_mid_run();
        test_start_spam();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
